// File: rtl/clock_select_pkg.sv
// Shared timer definitions: edge codes, CKS decode values and prescaler tap positions.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package timer_pkg;

    localparam int CLK_SELECT_BIT_WIDTH  = 5;
    localparam int EDGE_SELECT_BIT_WIDTH = 2;
    localparam int PRESCALER_WIDTH       = 13;

    // CounterEdge codes consumed by the TCNT counters
    localparam logic [EDGE_SELECT_BIT_WIDTH-1:0] PROHIBITED   = 2'b00;
    localparam logic [EDGE_SELECT_BIT_WIDTH-1:0] RISING_EDGE  = 2'b01;
    localparam logic [EDGE_SELECT_BIT_WIDTH-1:0] FALLING_EDGE = 2'b10;
    localparam logic [EDGE_SELECT_BIT_WIDTH-1:0] BOTH_EDGES   = 2'b11;

    // CKS[2:0] field of the select word
    localparam logic [2:0] CKS_DISABLED = 3'b000;
    localparam logic [2:0] CKS_INT_FAST = 3'b001;   // clk/8  or clk/2
    localparam logic [2:0] CKS_INT_MID  = 3'b010;   // clk/64 or clk/32
    localparam logic [2:0] CKS_INT_SLOW = 3'b011;   // clk/8192 or clk/1024
    localparam logic [2:0] CKS_CASCADE  = 3'b100;
    localparam logic [2:0] CKS_EXT_RISE = 3'b101;
    localparam logic [2:0] CKS_EXT_FALL = 3'b110;
    localparam logic [2:0] CKS_EXT_BOTH = 3'b111;

    // Prescaler bit giving each internal rate
    localparam int TAP_DIV2    = 0;
    localparam int TAP_DIV8    = 2;
    localparam int TAP_DIV32   = 4;
    localparam int TAP_DIV64   = 5;
    localparam int TAP_DIV1024 = 9;
    localparam int TAP_DIV8192 = 12;

    // Only the taps a channel can select are handed down from the shared prescaler
    typedef struct packed {
        logic div8192;
        logic div1024;
        logic div64;
        logic div32;
        logic div8;
        logic div2;
    } prescale_taps_t;

endpackage

// File: rtl/clock_select_if.sv
// Register-bank / counter side bundle of the clock selector (selects, TMCI pins, counter clocks).
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level/clock style, no handshake.
// Optional: CLOCK_SELECT_CASCADE_EN adds Overflow1 and CompareMatchA0.
interface clock_select_if;
    import timer_pkg::*;

    logic                             TMCI0;
    logic                             TMCI1;
    logic [CLK_SELECT_BIT_WIDTH-1:0]  clock_select_0;
    logic [CLK_SELECT_BIT_WIDTH-1:0]  clock_select_1;
`ifdef CLOCK_SELECT_CASCADE_EN
    logic                             Overflow1;
    logic                             CompareMatchA0;
`endif
    logic                             CounterClock0;
    logic [EDGE_SELECT_BIT_WIDTH-1:0] CounterEdge0;
    logic                             CounterClock1;
    logic [EDGE_SELECT_BIT_WIDTH-1:0] CounterEdge1;

    // master: register bank / pins / counters side
    modport master (
        output TMCI0, TMCI1, clock_select_0, clock_select_1,
`ifdef CLOCK_SELECT_CASCADE_EN
        output Overflow1, CompareMatchA0,
`endif
        input  CounterClock0, CounterEdge0, CounterClock1, CounterEdge1
    );

    // slave: the clock selector itself
    modport slave (
        input  TMCI0, TMCI1, clock_select_0, clock_select_1,
`ifdef CLOCK_SELECT_CASCADE_EN
        input  Overflow1, CompareMatchA0,
`endif
        output CounterClock0, CounterEdge0, CounterClock1, CounterEdge1
    );

endinterface

// File: rtl/clock_select_channel.sv
// One channel: TMCI synchroniser, select decode, select-change guard and output flops.
// Latency: internal/cascade source 1 clk, external pin 3 clk (2 sync + output flop).
// Backpressure: none.
// Ports: clk, rst_n, tmci (async pin), sel {ICKS1,ICKS0,CKS[2:0]}, taps (shared prescaler),
//        cascade_clk (only with CLOCK_SELECT_CASCADE_EN), counter_clock, counter_edge.
module clock_select_channel
    import timer_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             tmci,
    input  logic [CLK_SELECT_BIT_WIDTH-1:0]  sel,
    input  prescale_taps_t                   taps,
`ifdef CLOCK_SELECT_CASCADE_EN
    input  logic                             cascade_clk,
`endif
    output logic                             counter_clock,
    output logic [EDGE_SELECT_BIT_WIDTH-1:0] counter_edge
);

    logic                             tmci_meta;
    logic                             tmci_sync;
    logic [CLK_SELECT_BIT_WIDTH-1:0]  sel_prev;
    logic                             sel_changed;
    logic                             clock_nxt;
    logic [EDGE_SELECT_BIT_WIDTH-1:0] edge_nxt;

    // ICKS0 takes part in the change compare even though the decode ignores it
    assign sel_changed = (sel != sel_prev);

    always_comb begin
        clock_nxt = 1'b0;
        edge_nxt  = PROHIBITED;
        case (sel[2:0])
            CKS_INT_FAST: begin
                clock_nxt = sel[4] ? taps.div2 : taps.div8;
                edge_nxt  = RISING_EDGE;
            end
            CKS_INT_MID: begin
                clock_nxt = sel[4] ? taps.div32 : taps.div64;
                edge_nxt  = RISING_EDGE;
            end
            CKS_INT_SLOW: begin
                clock_nxt = sel[4] ? taps.div1024 : taps.div8192;
                edge_nxt  = RISING_EDGE;
            end
`ifdef CLOCK_SELECT_CASCADE_EN
            CKS_CASCADE: begin
                clock_nxt = cascade_clk;
                edge_nxt  = RISING_EDGE;
            end
`endif
            CKS_EXT_RISE: begin
                clock_nxt = tmci_sync;
                edge_nxt  = RISING_EDGE;
            end
            CKS_EXT_FALL: begin
                clock_nxt = tmci_sync;
                edge_nxt  = FALLING_EDGE;
            end
            CKS_EXT_BOTH: begin
                clock_nxt = tmci_sync;
                edge_nxt  = BOTH_EDGES;
            end
            default: ;
        endcase
        // One stopped cycle on any select change so the counter never sees
        // an edge manufactured by switching between two unrelated sources.
        if (sel_changed) begin
            clock_nxt = 1'b0;
            edge_nxt  = PROHIBITED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmci_meta     <= 1'b0;
            tmci_sync     <= 1'b0;
            sel_prev      <= '0;
            counter_clock <= 1'b0;
            counter_edge  <= PROHIBITED;
        end else begin
            tmci_meta     <= tmci;
            tmci_sync     <= tmci_meta;
            sel_prev      <= sel;
            counter_clock <= clock_nxt;
            counter_edge  <= edge_nxt;
        end
    end

endmodule

// File: rtl/clock_select.sv
// Dual-channel counter-clock selector for one 8-bit timer unit, with shared clk prescaler.
// Latency: internal/cascade source 1 clk, external TMCI pin 3 clk.
// Backpressure: none; outputs are free-running registered clocks.
// Ports: clk, rst_n, bus (clock_select_if.slave: TMCI0/1, clock_select_0/1, CounterClock0/1,
//        CounterEdge0/1, plus Overflow1/CompareMatchA0 when CLOCK_SELECT_CASCADE_EN is defined).
module clock_select
    import timer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    clock_select_if.slave bus
);

    logic [PRESCALER_WIDTH-1:0] prescaler;
    prescale_taps_t             taps;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRESCALER_WIDTH'(1);   // wraps 8191 -> 0
        end
    end

    assign taps.div2    = prescaler[TAP_DIV2];
    assign taps.div8    = prescaler[TAP_DIV8];
    assign taps.div32   = prescaler[TAP_DIV32];
    assign taps.div64   = prescaler[TAP_DIV64];
    assign taps.div1024 = prescaler[TAP_DIV1024];
    assign taps.div8192 = prescaler[TAP_DIV8192];

    // Cascade: channel 0 counts channel 1 overflows, channel 1 counts channel 0 compare-match A
    clock_select_channel u_ch0 (
        .clk           (clk),
        .rst_n         (rst_n),
        .tmci          (bus.TMCI0),
        .sel           (bus.clock_select_0),
        .taps          (taps),
`ifdef CLOCK_SELECT_CASCADE_EN
        .cascade_clk   (bus.Overflow1),
`endif
        .counter_clock (bus.CounterClock0),
        .counter_edge  (bus.CounterEdge0)
    );

    clock_select_channel u_ch1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .tmci          (bus.TMCI1),
        .sel           (bus.clock_select_1),
        .taps          (taps),
`ifdef CLOCK_SELECT_CASCADE_EN
        .cascade_clk   (bus.CompareMatchA0),
`endif
        .counter_clock (bus.CounterClock1),
        .counter_edge  (bus.CounterEdge1)
    );

endmodule

// File: tb/tb_clock_select.sv
// Self-checking bench for clock_select against a cycle-level behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_clock_select;
    import timer_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clock_select_if bus ();

    clock_select dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- behavioural reference model ----------------
    // Counter clock after clk edge k: internal rates are the square wave
    // (k-1 / half-period) mod 2, external pins appear after being sampled two
    // edges earlier, and a select that differs from the previous edge's select
    // produces one stopped cycle.
    int         m_pre   = 0;
    logic       m_a0    = 1'b0, m_b0 = 1'b0, m_a1 = 1'b0, m_b1 = 1'b0;
    logic [4:0] m_last0 = '0, m_last1 = '0;
    logic [2:0] m_exp0  = '0, m_exp1 = '0;

    function automatic logic [2:0] ref_out(input logic [4:0] sel, input int pre,
                                           input logic ext, input logic casc);
        int half;
        case (sel[2:0])
            3'd1:    half = sel[4] ? 1   : 4;
            3'd2:    half = sel[4] ? 16  : 32;
            3'd3:    half = sel[4] ? 512 : 4096;
            default: half = 0;
        endcase
        if (half != 0) return {((pre / half) % 2) == 1, 2'b01};
        case (sel[2:0])
`ifdef CLOCK_SELECT_CASCADE_EN
            3'd4:    return {casc, 2'b01};
`endif
            3'd5:    return {ext, 2'b01};
            3'd6:    return {ext, 2'b10};
            3'd7:    return {ext, 2'b11};
            default: return 3'b000;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic c0, c1;
        if (!rst_n) begin
            m_pre = 0; m_a0 = 0; m_b0 = 0; m_a1 = 0; m_b1 = 0;
            m_last0 = '0; m_last1 = '0; m_exp0 = '0; m_exp1 = '0;
        end else begin
            c0 = 1'b0; c1 = 1'b0;
`ifdef CLOCK_SELECT_CASCADE_EN
            c0 = bus.Overflow1;
            c1 = bus.CompareMatchA0;
`endif
            m_exp0 = (bus.clock_select_0 != m_last0) ? 3'b000 : ref_out(bus.clock_select_0, m_pre, m_b0, c0);
            m_exp1 = (bus.clock_select_1 != m_last1) ? 3'b000 : ref_out(bus.clock_select_1, m_pre, m_b1, c1);
            m_last0 = bus.clock_select_0;
            m_last1 = bus.clock_select_1;
            m_b0 = m_a0; m_a0 = bus.TMCI0;
            m_b1 = m_a1; m_a1 = bus.TMCI1;
            m_pre = (m_pre + 1) % 8192;
        end
    end

    // advance one clock; inputs change and outputs are sampled on the falling edge
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.clock_select_0 = 5'b00101;
        bus.clock_select_1 = 5'b00111;
        bus.TMCI0 = 1'b1;
        bus.TMCI1 = 1'b1;
        repeat (6) cyc();
        checks++;
        if ({bus.CounterClock0, bus.CounterEdge0, bus.CounterClock1, bus.CounterEdge1} !== 6'b101_111) begin
            errors++;
            $display("FAIL reset_pre: got %b expected %b",
                     {bus.CounterClock0, bus.CounterEdge0, bus.CounterClock1, bus.CounterEdge1}, 6'b101_111);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.CounterClock0, bus.CounterEdge0, bus.CounterClock1, bus.CounterEdge1} !== 6'b000_000) begin
            errors++;
            $display("FAIL reset_async: got %b expected 000000",
                     {bus.CounterClock0, bus.CounterEdge0, bus.CounterClock1, bus.CounterEdge1});
        end
        @(negedge clk);
        bus.clock_select_0 = 5'b00001;
        bus.clock_select_1 = 5'b00000;
        bus.TMCI0 = 1'b0;
        bus.TMCI1 = 1'b0;
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            logic       e_clk;
            logic [1:0] e_edge;
            cyc();
            e_clk  = (((k - 1) / 4) % 2) == 1;
            e_edge = (k == 1) ? 2'b00 : 2'b01;
            checks++;
            if ({bus.CounterClock0, bus.CounterEdge0} !== {e_clk, e_edge}) begin
                errors++;
                $display("FAIL reset_div8 edge%0d: got %b expected %b", k,
                         {bus.CounterClock0, bus.CounterEdge0}, {e_clk, e_edge});
            end
            checks++;
            if ({bus.CounterClock0, bus.CounterEdge0} !== m_exp0) begin
                errors++;
                $display("FAIL reset_model edge%0d: got %b expected %b", k,
                         {bus.CounterClock0, bus.CounterEdge0}, m_exp0);
            end
        end
    endtask

    task automatic test_internal_rates();
        logic [4:0] codes [5];
        int         periods [5];
        codes   = '{5'b10001, 5'b00010, 5'b10010, 5'b00011, 5'b10011};
        periods = '{2, 64, 32, 8192, 1024};
        for (int r = 0; r < 5; r++) begin
            int   t_first, t_second, bound;
            logic prev;
            t_first  = -1;
            t_second = -1;
            bound    = 3 * periods[r] + 8;
            bus.clock_select_1 = codes[r];
            cyc();
            cyc();
            prev = bus.CounterClock1;
            for (int n = 1; n <= bound && t_second < 0; n++) begin
                cyc();
                checks++;
                if ({bus.CounterClock1, bus.CounterEdge1} !== m_exp1) begin
                    errors++;
                    $display("FAIL rate_model sel=%b: got %b expected %b", codes[r],
                             {bus.CounterClock1, bus.CounterEdge1}, m_exp1);
                end
                if (!prev && bus.CounterClock1) begin
                    if (t_first < 0) t_first = n;
                    else             t_second = n;
                end
                prev = bus.CounterClock1;
            end
            checks++;
            if (t_second < 0) begin
                errors++;
                $display("FAIL rate_timeout sel=%b: no two rises within %0d clks", codes[r], bound);
            end else if (t_second - t_first != periods[r]) begin
                errors++;
                $display("FAIL rate_period sel=%b: got %0d expected %0d", codes[r],
                         t_second - t_first, periods[r]);
            end
            checks++;
            if (bus.CounterEdge1 !== 2'b01) begin
                errors++;
                $display("FAIL rate_edge sel=%b: got %b expected 01", codes[r], bus.CounterEdge1);
            end
        end
    endtask

    task automatic test_external();
        logic [4:0] codes [3];
        logic [1:0] edges [3];
        logic       hist [60];
        codes = '{5'b00101, 5'b00110, 5'b00111};
        edges = '{2'b01, 2'b10, 2'b11};
        for (int r = 0; r < 3; r++) begin
            bus.clock_select_0 = codes[r];
            for (int i = 0; i < 60; i++) begin
                if (i % 10 == 0) bus.TMCI0 = ~bus.TMCI0;
                hist[i] = bus.TMCI0;
                cyc();
                checks++;
                if ({bus.CounterClock0, bus.CounterEdge0} !== m_exp0) begin
                    errors++;
                    $display("FAIL ext_model sel=%b i=%0d: got %b expected %b", codes[r], i,
                             {bus.CounterClock0, bus.CounterEdge0}, m_exp0);
                end
                if (i >= 2) begin
                    checks++;
                    if ({bus.CounterClock0, bus.CounterEdge0} !== {hist[i-2], edges[r]}) begin
                        errors++;
                        $display("FAIL ext_delay sel=%b i=%0d: got %b expected %b", codes[r], i,
                                 {bus.CounterClock0, bus.CounterEdge0}, {hist[i-2], edges[r]});
                    end
                end
            end
        end
    endtask

    task automatic test_disabled();
        logic [1:0] e1;
`ifdef CLOCK_SELECT_CASCADE_EN
        e1 = 2'b01;
        bus.CompareMatchA0 = 1'b0;
`else
        e1 = 2'b00;
`endif
        bus.clock_select_0 = 5'b00000;
        bus.clock_select_1 = 5'b00100;
        cyc();
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) begin
                bus.TMCI0 = ~bus.TMCI0;
                bus.TMCI1 = ~bus.TMCI1;
            end
            cyc();
            checks++;
            if ({bus.CounterClock0, bus.CounterEdge0, bus.CounterClock1, bus.CounterEdge1} !== {3'b000, 1'b0, e1}) begin
                errors++;
                $display("FAIL disabled i=%0d: got %b expected %b", i,
                         {bus.CounterClock0, bus.CounterEdge0, bus.CounterClock1, bus.CounterEdge1},
                         {3'b000, 1'b0, e1});
            end
        end
    endtask

    task automatic test_select_change();
        bus.clock_select_0 = 5'b00101;
        bus.TMCI0 = 1'b1;
        repeat (6) cyc();
        checks++;
        if ({bus.CounterClock0, bus.CounterEdge0} !== 3'b101) begin
            errors++;
            $display("FAIL selchg_pre: got %b expected 101", {bus.CounterClock0, bus.CounterEdge0});
        end
        bus.clock_select_0 = 5'b00001;
        cyc();
        checks++;
        if ({bus.CounterClock0, bus.CounterEdge0} !== 3'b000) begin
            errors++;
            $display("FAIL selchg_guard: got %b expected 000", {bus.CounterClock0, bus.CounterEdge0});
        end
        for (int i = 0; i < 16; i++) begin
            cyc();
            checks++;
            if (bus.CounterEdge0 !== 2'b01 || {bus.CounterClock0, bus.CounterEdge0} !== m_exp0) begin
                errors++;
                $display("FAIL selchg_follow i=%0d: got %b expected %b", i,
                         {bus.CounterClock0, bus.CounterEdge0}, m_exp0);
            end
        end
    endtask

`ifdef CLOCK_SELECT_CASCADE_EN
    task automatic test_cascade();
        bus.clock_select_0 = 5'b00100;
        bus.clock_select_1 = 5'b00100;
        bus.Overflow1      = 1'b0;
        bus.CompareMatchA0 = 1'b0;
        repeat (3) cyc();
        bus.Overflow1 = 1'b1;
        cyc();
        bus.Overflow1 = 1'b0;
        checks++;
        if ({bus.CounterClock0, bus.CounterEdge0} !== 3'b101) begin
            errors++;
            $display("FAIL cascade0_hi: got %b expected 101", {bus.CounterClock0, bus.CounterEdge0});
        end
        cyc();
        checks++;
        if ({bus.CounterClock0, bus.CounterEdge0} !== 3'b001) begin
            errors++;
            $display("FAIL cascade0_lo: got %b expected 001", {bus.CounterClock0, bus.CounterEdge0});
        end
        bus.CompareMatchA0 = 1'b1;
        cyc();
        bus.CompareMatchA0 = 1'b0;
        checks++;
        if ({bus.CounterClock1, bus.CounterEdge1, bus.CounterClock0} !== 4'b1010) begin
            errors++;
            $display("FAIL cascade1_hi: got %b expected 1010",
                     {bus.CounterClock1, bus.CounterEdge1, bus.CounterClock0});
        end
        cyc();
        checks++;
        if ({bus.CounterClock1, bus.CounterEdge1} !== 3'b001) begin
            errors++;
            $display("FAIL cascade1_lo: got %b expected 001", {bus.CounterClock1, bus.CounterEdge1});
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) bus.clock_select_0 = 5'($urandom);
            if ($urandom_range(39) == 0) bus.clock_select_1 = 5'($urandom);
            if ($urandom_range(3) == 0)  bus.TMCI0 = ~bus.TMCI0;
            if ($urandom_range(3) == 0)  bus.TMCI1 = ~bus.TMCI1;
`ifdef CLOCK_SELECT_CASCADE_EN
            bus.Overflow1      = ($urandom_range(4) == 0);
            bus.CompareMatchA0 = ($urandom_range(4) == 0);
`endif
            cyc();
            checks++;
            if ({bus.CounterClock0, bus.CounterEdge0} !== m_exp0) begin
                errors++;
                $display("FAIL random_ch0 i=%0d sel=%b: got %b expected %b", i, bus.clock_select_0,
                         {bus.CounterClock0, bus.CounterEdge0}, m_exp0);
            end
            checks++;
            if ({bus.CounterClock1, bus.CounterEdge1} !== m_exp1) begin
                errors++;
                $display("FAIL random_ch1 i=%0d sel=%b: got %b expected %b", i, bus.clock_select_1,
                         {bus.CounterClock1, bus.CounterEdge1}, m_exp1);
            end
        end
    endtask

    initial begin
        bus.TMCI0 = 1'b0;
        bus.TMCI1 = 1'b0;
        bus.clock_select_0 = '0;
        bus.clock_select_1 = '0;
`ifdef CLOCK_SELECT_CASCADE_EN
        bus.Overflow1      = 1'b0;
        bus.CompareMatchA0 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_internal_rates();
        test_external();
        test_disabled();
        test_select_change();
`ifdef CLOCK_SELECT_CASCADE_EN
        test_cascade();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
